// File: rtl/route_lookup_engine.sv
// route_lookup_engine: BCAM lookup, 4-word entry burst read and header rewrite toward the encoder.
// Define ROUTE_LOOKUP_MISS_DROP_EN to turn BCAM misses into drop records instead of default-hop forwards.
module route_lookup_engine #(
  parameter int MEMDBITS      = 9,
  parameter int HOP_BITS      = 3,
  parameter int RD_LAT        = 1,
  parameter int MATCH_TIMEOUT = 16,
  parameter int DEFAULT_HOP   = 0
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                f_drop,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [47:0]         dec_dest_addr,
  input  logic [47:0]         dec_src_addr,
  input  logic [31:0]         dec_ip_dest_addr,
  input  logic [31:0]         dec_ip_src_addr,
  input  logic [15:0]         dec_udp_dest_port,
  input  logic [15:0]         dec_udp_src_port,
  output logic                match_enable,
  output logic [47:0]         match_key,
  input  logic                match_found,
  input  logic [MEMDBITS-1:0] match_addr,
  output logic                read_enable,
  output logic [MEMDBITS-1:0] read_address,
  input  logic [31:0]         read_data,
  output logic                enc_valid,
  input  logic                enc_ready,
  output logic [47:0]         enc_dest_addr,
  output logic [47:0]         enc_src_addr,
  output logic [31:0]         enc_ip_dest_addr,
  output logic [31:0]         enc_ip_src_addr,
  output logic [15:0]         enc_udp_dest_port,
  output logic [15:0]         enc_udp_src_port,
  output logic                enc_drop,
  output logic [HOP_BITS-1:0] enc_next_hop,
  output logic [15:0]         miss_count
);
  typedef enum logic [2:0] {IDLE, MATCH, READ, OUT, DROP} st_e;
  typedef struct packed {
    st_e                 st;
    logic [7:0]          tmo;
    logic [RD_LAT-1:0]   rv;
    logic [2:0]          iss;
    logic [1:0]          cap;
    logic                me;
    logic                re;
    logic [MEMDBITS-1:0] addr;
    logic [47:0]         key;
    logic [31:0]         ip;
    logic [15:0]         port;
    logic                ev;
    logic                drop;
    logic [47:0]         dst;
    logic [47:0]         src;
    logic [31:0]         ipd;
    logic [31:0]         ips;
    logic [15:0]         udpd;
    logic [15:0]         udps;
    logic [HOP_BITS-1:0] hop;
    logic [15:0]         miss;
  } regs_t;
  regs_t r_q, r_d;
  // rv tracks issued reads so a return is captured exactly RD_LAT cycles after its strobe
  always_comb begin
    r_d = r_q;
    r_d.rv = RD_LAT'({r_q.rv, r_q.re});
    case (r_q.st)
      IDLE: if (dec_valid) begin
        r_d.st   = MATCH;
        r_d.me   = 1'b1;
        r_d.tmo  = '0;
        r_d.key  = dec_dest_addr;
        r_d.ip   = dec_ip_dest_addr;
        r_d.port = dec_udp_dest_port;
        r_d.dst  = dec_dest_addr;
        r_d.src  = dec_src_addr;
        r_d.ipd  = dec_ip_dest_addr;
        r_d.ips  = dec_ip_src_addr;
        r_d.udpd = dec_udp_dest_port;
        r_d.udps = dec_udp_src_port;
      end
      MATCH: if (match_found) begin
        r_d.st   = READ;
        r_d.me   = 1'b0;
        r_d.re   = 1'b1;
        r_d.addr = match_addr + MEMDBITS'(1);
        r_d.iss  = 3'd1;
        r_d.cap  = 2'd0;
      end else if (r_q.tmo == 8'(MATCH_TIMEOUT - 1)) begin
        r_d.me   = 1'b0;
        r_d.ev   = 1'b1;
        r_d.miss = &r_q.miss ? r_q.miss : r_q.miss + 16'd1;
`ifdef ROUTE_LOOKUP_MISS_DROP_EN
        r_d.st   = DROP;
        r_d.drop = 1'b1;
        r_d.hop  = '0;
`else
        r_d.st   = OUT;
        r_d.hop  = HOP_BITS'(DEFAULT_HOP);
`endif
      end else r_d.tmo = r_q.tmo + 8'd1;
      READ: begin
        r_d.re   = r_q.iss != 3'd4;
        r_d.iss  = r_q.iss == 3'd4 ? r_q.iss : r_q.iss + 3'd1;
        r_d.addr = r_q.iss == 3'd4 ? r_q.addr : r_q.addr + MEMDBITS'(1);
        if (r_q.rv[RD_LAT-1]) begin
          r_d.cap = r_q.cap + 2'd1;
          case (r_q.cap)
            2'd0: r_d.ipd = read_data;
            2'd1: r_d.dst[47:16] = read_data;
            2'd2: begin
              r_d.dst[15:0] = read_data[31:16];
              r_d.udpd      = read_data[15:0];
            end
            default: begin
              r_d.hop = read_data[HOP_BITS-1:0];
              r_d.st  = OUT;
              r_d.ev  = 1'b1;
            end
          endcase
        end
      end
      default: if (enc_ready) begin
        r_d.st   = IDLE;
        r_d.ev   = 1'b0;
        r_d.drop = 1'b0;
      end
    endcase
    if (f_drop && (r_q.st == MATCH || r_q.st == READ)) begin
      r_d.st   = DROP;
      r_d.me   = 1'b0;
      r_d.re   = 1'b0;
      r_d.rv   = '0;
      r_d.ev   = 1'b1;
      r_d.drop = 1'b1;
      r_d.hop  = '0;
      r_d.dst  = r_q.key;
      r_d.ipd  = r_q.ip;
      r_d.udpd = r_q.port;
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_q <= '0;
    else r_q <= r_d;
  assign dec_ready         = r_q.st == IDLE;
  assign match_enable      = r_q.me;
  assign match_key         = r_q.key;
  assign read_enable       = r_q.re;
  assign read_address      = r_q.addr;
  assign enc_valid         = r_q.ev;
  assign enc_dest_addr     = r_q.dst;
  assign enc_src_addr      = r_q.src;
  assign enc_ip_dest_addr  = r_q.ipd;
  assign enc_ip_src_addr   = r_q.ips;
  assign enc_udp_dest_port = r_q.udpd;
  assign enc_udp_src_port  = r_q.udps;
  assign enc_drop          = r_q.drop;
  assign enc_next_hop      = r_q.hop;
  assign miss_count        = r_q.miss;
endmodule

// File: tb/tb_route_lookup_engine.sv
// tb_route_lookup_engine: randomized packets against a per-packet record model with BCAM and memory models.
module tb_route_lookup_engine;
  localparam int MB = 9, HB = 3, RL = 1, TO = 16, DH = 0;
  logic clk = 1'b0, resetn = 1'b0;
  logic f_drop = 1'b0, dec_valid = 1'b0, dec_ready;
  logic [47:0] dec_dest_addr = '0, dec_src_addr = '0;
  logic [31:0] dec_ip_dest_addr = '0, dec_ip_src_addr = '0;
  logic [15:0] dec_udp_dest_port = '0, dec_udp_src_port = '0;
  logic match_enable, match_found = 1'b0, read_enable, enc_valid, enc_ready = 1'b0, enc_drop;
  logic [47:0] match_key, enc_dest_addr, enc_src_addr;
  logic [MB-1:0] match_addr = '0, read_address;
  logic [31:0] read_data, enc_ip_dest_addr, enc_ip_src_addr;
  logic [15:0] enc_udp_dest_port, enc_udp_src_port, miss_count;
  logic [HB-1:0] enc_next_hop;
  always #5 clk = ~clk;
  route_lookup_engine #(.MEMDBITS(MB), .HOP_BITS(HB), .RD_LAT(RL), .MATCH_TIMEOUT(TO), .DEFAULT_HOP(DH)) dut (
    .clk(clk), .resetn(resetn), .f_drop(f_drop), .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_dest_addr(dec_dest_addr), .dec_src_addr(dec_src_addr),
    .dec_ip_dest_addr(dec_ip_dest_addr), .dec_ip_src_addr(dec_ip_src_addr),
    .dec_udp_dest_port(dec_udp_dest_port), .dec_udp_src_port(dec_udp_src_port),
    .match_enable(match_enable), .match_key(match_key), .match_found(match_found), .match_addr(match_addr),
    .read_enable(read_enable), .read_address(read_address), .read_data(read_data),
    .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_dest_addr(enc_dest_addr), .enc_src_addr(enc_src_addr),
    .enc_ip_dest_addr(enc_ip_dest_addr), .enc_ip_src_addr(enc_ip_src_addr),
    .enc_udp_dest_port(enc_udp_dest_port), .enc_udp_src_port(enc_udp_src_port),
    .enc_drop(enc_drop), .enc_next_hop(enc_next_hop), .miss_count(miss_count));
  int checks = 0, failures = 0, exp_miss = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [31:0] mem [1<<MB];
  logic [31:0] pipe [RL];
  logic [MB-1:0] rq [$];
  always @(posedge clk) begin
    if (read_enable) rq.push_back(read_address);
    pipe[0] <= read_enable ? mem[read_address] : $urandom;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign read_data = pipe[RL-1];
  typedef struct {
    logic [47:0] d, s;
    logic [31:0] id, is;
    logic [15:0] ud, us;
    logic dr;
    logic [HB-1:0] hp;
  } rec_t;
  task automatic chk_rec(input string t, input rec_t e);
    chk({t, ".dmac"}, enc_dest_addr, e.d);
    chk({t, ".smac"}, enc_src_addr, e.s);
    chk({t, ".dip"}, enc_ip_dest_addr, e.id);
    chk({t, ".sip"}, enc_ip_src_addr, e.is);
    chk({t, ".dport"}, enc_udp_dest_port, e.ud);
    chk({t, ".sport"}, enc_udp_src_port, e.us);
    chk({t, ".drop"}, enc_drop, e.dr);
    chk({t, ".hop"}, enc_next_hop, e.hp);
  endtask
  // mode 0 hit, 1 miss, 2 drop in MATCH (j cycles after enable), 3 drop in READ (j cycles after 1st issue)
  task automatic run_pkt(input int mode, input logic [MB-1:0] a, input int L, input int j, input logic [47:0] dst,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3, input logic [31:0] w4,
                         input int bp);
    rec_t e;
    int n, dn, nexp, nrd;
    mem[MB'(a + 1)] = w1;
    mem[MB'(a + 2)] = w2;
    mem[MB'(a + 3)] = w3;
    mem[MB'(a + 4)] = w4;
    e.d = dst;
    e.s = 48'({$urandom(), $urandom()});
    e.id = $urandom;
    e.is = $urandom;
    e.ud = 16'($urandom);
    e.us = 16'($urandom);
    e.dr = 1'b0;
    e.hp = '0;
    dn = -1;
    nrd = 0;
    if (mode == 0) begin
      e.d = {w2, w3[31:16]};
      e.id = w1;
      e.ud = w3[15:0];
      e.hp = w4[HB-1:0];
      nexp = 6 + RL + L;
      nrd = 4;
    end else if (mode == 1) begin
      nexp = TO + 1;
      exp_miss++;
`ifdef ROUTE_LOOKUP_MISS_DROP_EN
      e.dr = 1'b1;
`else
      e.hp = HB'(DH);
`endif
    end else begin
      dn = mode == 2 ? 1 + j : L + 2 + j;
      nexp = dn + 1;
      nrd = mode == 2 ? 0 : (j + 1 > 4 ? 4 : j + 1);
      e.dr = 1'b1;
    end
    rq.delete();
    chk("idle_ready", dec_ready, 1'b1);
    dec_valid = 1'b1;
    dec_dest_addr = dst;
    dec_src_addr = e.s;
    dec_ip_dest_addr = e.id;
    dec_ip_src_addr = e.is;
    dec_udp_dest_port = e.ud;
    dec_udp_src_port = e.us;
    if (mode == 0) begin
      dec_ip_dest_addr = $urandom;
      dec_udp_dest_port = 16'($urandom);
    end
    f_drop = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    dec_valid = 1'b0;
    f_drop = 1'b0;
    chk("match_en", match_enable, 1'b1);
    chk("match_key", match_key, dst);
    chk("busy_ready", dec_ready, 1'b0);
    n = 1;
    while (!enc_valid && n <= 100) begin
      match_found = mode != 1 && n == 1 + L;
      match_addr = a;
      f_drop = n == dn;
      @(negedge clk);
      n++;
    end
    match_found = 1'b0;
    f_drop = 1'b0;
    chk("latency", n, nexp);
    chk("strobes_off", {match_enable, read_enable}, 2'b00);
    chk("nreads", rq.size(), nrd);
    for (int i = 0; i < rq.size() && i < nrd; i++) chk("raddr", rq[i], MB'(a + i + 1));
    chk_rec("rec", e);
    for (int i = 0; i < bp; i++) begin
      f_drop = 1'($urandom_range(0, 1));
      chk("hold_ready", dec_ready, 1'b0);
      chk("hold_valid", enc_valid, 1'b1);
      chk_rec("hold", e);
      @(negedge clk);
    end
    f_drop = 1'b0;
    enc_ready = 1'b1;
    @(negedge clk);
    enc_ready = 1'b0;
    chk("post_valid", enc_valid, 1'b0);
    chk("post_ready", dec_ready, 1'b1);
    chk("miss_count", miss_count, exp_miss);
  endtask
  task automatic chk_zero(input string t);
    chk({t, ".ready"}, dec_ready, 1'b1);
    chk({t, ".strobes"}, {enc_valid, match_enable, read_enable, enc_drop}, 4'b0);
    chk({t, ".miss"}, miss_count, 16'h0);
    chk({t, ".addr"}, read_address, '0);
    chk({t, ".key"}, match_key, '0);
    chk({t, ".dmac"}, enc_dest_addr, '0);
    chk({t, ".hop"}, enc_next_hop, '0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    resetn = 1'b1;
    @(negedge clk);
    run_pkt(0, 9'h010, 0, 0, 48'h0A0B0C0D0E0F, 32'hC0A80005, 32'h11223344, 32'h55661F90, 32'h5, 10);
    run_pkt(0, 9'h1FE, 2, 0, 48'h123456789ABC, $urandom, $urandom, $urandom, $urandom, 0);
    run_pkt(1, 9'h000, 0, 0, 48'hCAFEF00D0001, $urandom, $urandom, $urandom, $urandom, 3);
    run_pkt(3, 9'h040, 1, 1, 48'hDEADBEEF0002, $urandom, $urandom, $urandom, $urandom, 2);
    run_pkt(0, 9'h041, 0, 0, 48'hDEADBEEF0003, $urandom, $urandom, $urandom, $urandom, 0);
    run_pkt(2, 9'h050, 3, 3, 48'h00000000BEEF, $urandom, $urandom, $urandom, $urandom, 1);
    for (int k = 0; k < 40; k++) begin
      int m, l, jj;
      m = $urandom_range(0, 3);
      l = $urandom_range(0, TO - 1);
      jj = m == 2 ? $urandom_range(0, l) : $urandom_range(0, 3 + RL);
      run_pkt(m, 9'($urandom), l, jj, 48'({$urandom(), $urandom()}), $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 4));
    end
    dec_valid = 1'b1;
    dec_dest_addr = 48'h0102030405AA;
    @(posedge clk);
    @(negedge clk);
    dec_valid = 1'b0;
    match_found = 1'b1;
    match_addr = 9'h020;
    @(negedge clk);
    match_found = 1'b0;
    chk("re_on", read_enable, 1'b1);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_zero("async_rst");
    exp_miss = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_quiet", {enc_valid, match_enable, read_enable}, 3'b000);
    end
    run_pkt(0, 9'h0AA, 4, 0, 48'h0F0E0D0C0B0A, $urandom, $urandom, $urandom, $urandom, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/route_lookup_engine.md
# route_lookup_engine

Parametrised successor to the router's algorithm FSM. Accepts one decoded packet header at a time, queries the BCAM for the destination MAC, and burst-reads the matched entry: real IP, MAC, UDP port and next hop. It then hands a rewritten header plus next-hop code to the encoder over a valid/ready handshake. Adds configurable memory depth, hop width and read latency, a match timeout with miss handling, and proper back-pressure on both sides.

## Interface
- MEMDBITS, 9, memory address width; depth 2^MEMDBITS words of 32 bits.
- HOP_BITS, 3, width of next-hop code.
- RD_LAT, 1, read_data valid RD_LAT cycles after read_enable (legal 1..3).
- MATCH_TIMEOUT, 16, cycles in MATCH without match_found before a miss is declared (legal 1..255).
- DEFAULT_HOP, 0, next hop used on a forwarded miss.

Ports:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- f_drop  in  1  firewall drop request for the in-flight packet.
- dec_valid / dec_ready  in / out  1 / 1  decoder handshake.
- dec_dest_addr, dec_src_addr  in  48  Ethernet destination / source.
- dec_ip_dest_addr, dec_ip_src_addr  in  32  IP destination / source.
- dec_udp_dest_port, dec_udp_src_port  in  16  UDP destination / source port.
- match_enable  out  1  BCAM search strobe.
- match_key  out  48  search key; equals latched dest MAC.
- match_found  in  1  hit.
- match_addr  in  MEMDBITS  base address of the hit entry; valid with match_found.
- read_enable  out  1  memory read strobe.
- read_address  out  MEMDBITS  read address.
- read_data  in  32  read word.
- enc_valid / enc_ready  out / in  1 / 1  encoder handshake.
- enc_dest_addr, enc_src_addr  out  48  Ethernet destination / source to encoder.
- enc_ip_dest_addr, enc_ip_src_addr  out  32  IP destination / source to encoder.
- enc_udp_dest_port, enc_udp_src_port  out  16  UDP destination / source to encoder.
- enc_drop  out  1  record marks a dropped packet.
- enc_next_hop  out  HOP_BITS  routing port.
- miss_count  out  16  saturating count of BCAM misses.

## Operation
- States: IDLE, MATCH, READ, OUT, DROP.
- IDLE:
  - dec_ready=1.
  - On dec_valid&dec_ready, latch all six header fields → MATCH.
  - f_drop ignored.
- MATCH:
  - match_enable=1, match_key=latched dest MAC.
  - Timeout counter increments each cycle.
  - match_found → latch match_addr → READ.
  - MATCH_TIMEOUT cycles without a hit → miss: miss_count++ (saturating at 0xFFFF), miss handling per Configuration.
- READ:
  - Issues 4 back-to-back reads at match_addr+1..+4; addition is modulo 2^MEMDBITS (wraps).
  - Captures, in order:
    - word1 → real dest IP.
    - word2 → MAC[47:16].
    - word3[31:16] → MAC[15:0]; word3[15:0] → UDP dest port.
    - word4[HOP_BITS-1:0] → hop.
  - After the 4th capture → OUT.
- OUT:
  - enc_valid=1 with dest MAC, real IP and port from memory, latched source fields, enc_drop=0, hop.
  - Outputs held stable until enc_ready; on enc_valid&enc_ready → IDLE.
  - f_drop ignored (record committed).
- DROP:
  - enc_valid=1, enc_drop=1, all original latched header fields, enc_next_hop=0.
  - Held until enc_ready, then → IDLE.
- f_drop in MATCH or READ: abort immediately.
  - Deassert match_enable/read_enable next cycle.
  - Discard outstanding read returns.
  - → DROP.
- f_drop and match_found in the same cycle: drop wins.

## Timing
- All outputs registered except dec_ready (decoded from state).
- Reset values:
  - state IDLE, dec_ready=1.
  - All other outputs 0, including enc_valid, match_enable, read_enable, miss_count.
- Accept at edge T:
  - match_enable high T+1.
  - If match_found is sampled at T+1, reads issue T+2..T+5.
  - enc_valid rises at T+6+RD_LAT.
- Miss: enc_valid rises at T+MATCH_TIMEOUT+1.
- Back-to-back throughput: next dec accept possible in the cycle after the enc handshake completes.
- Reset asserted mid-operation: immediate return to reset values; latched packet is lost, no record emitted.

## Configuration
- ROUTE_LOOKUP_MISS_DROP_EN defined: a miss goes to DROP (enc_drop=1, hop 0).
- Undefined: a miss goes to OUT with original header fields, enc_drop=0, enc_next_hop=DEFAULT_HOP.
- miss_count behaves identically in both builds.

## Test plan
- Hit, RD_LAT=1: dest MAC 0x0A0B0C0D0E0F, match_addr=0x010, mem[0x11..0x14]={0xC0A80005, 0x11223344, 0x5566_1F90, 0x5} → enc_valid at T+7 with IP 0xC0A80005, MAC 0x112233445566, port 0x1F90, hop 5, enc_drop=0.
- Address wrap, MEMDBITS=9: match_addr=0x1FE → read_address sequence 0x1FF, 0x000, 0x001, 0x002.
- Miss, MATCH_TIMEOUT=16:
  - Macro undefined → enc_valid at T+17, original fields, hop DEFAULT_HOP, miss_count=1.
  - Macro defined → enc_drop=1.
- f_drop pulsed during the 2nd read issue → read_enable low next cycle; DROP record with original fields and enc_drop=1; late read_data ignored; next packet routes correctly.
- Encoder back-pressure: enc_ready=0 for 10 cycles → enc_* stable and dec_ready=0 throughout; f_drop during OUT has no effect.
- resetn pulled low during READ → all outputs 0 and dec_ready=1 asynchronously; no enc_valid after release until a new accept.
